// File: rtl/encoder_speed_meter_pkg.sv
// Shared types and helpers for the quadrature encoder speed meter.
// Step codes, gate FSM states and signed saturation limits.
package encoder_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int sat_max(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(int w);
    return -(1 << (w - 1));
  endfunction

  // Map {a,b} onto its position in the 00-01-11-10 Gray cycle.
  function automatic logic [1:0] gray_idx(logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/encoder_speed_meter_if.sv
// Encoder inputs, control and speed/position/status outputs.
// master drives the encoder lines; slave is the meter.
interface encoder_speed_meter_if #(
  parameter int CNT_W = 16
);
  logic                    enc_a;
  logic                    enc_b;
  logic                    enable;
  logic                    clr_err;
  logic signed [CNT_W-1:0] speed;
  logic                    speed_valid;
  logic signed [31:0]      pos;
  logic                    sat_err;
  logic                    quad_err;

  modport master (
    output enc_a, enc_b, enable, clr_err,
    input  speed, speed_valid, pos,
    input  sat_err, quad_err
  );

  modport slave (
    input  enc_a, enc_b, enable, clr_err,
    output speed, speed_valid, pos,
    output sat_err, quad_err
  );
endinterface

// File: rtl/encoder_speed_meter_glitch_filter.sv
// 2-FF synchroniser plus stability filter for one encoder line.
// Output follows only after FILT_LEN identical synced samples.
module enc_glitch_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILT_LEN + 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) lvl_d = s2_q;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = lvl_q;
endmodule

// File: rtl/encoder_speed_meter.sv
// x4 quadrature decoder with gated signed step counter.
// Emits one speed sample per GATE_CYCLES window while enabled.
module encoder_speed_meter #(
  parameter int GATE_CYCLES = 5_000_000,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 16
) (
  input  logic ACLK,
  input  logic ARESETN,
  encoder_speed_meter_if.slave bus
);
  import encoder_pkg::*;

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic signed [CNT_W-1:0] SMAX = CNT_W'(sat_max(CNT_W));
  localparam logic signed [CNT_W-1:0] SMIN = CNT_W'(sat_min(CNT_W));
  localparam logic signed [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [GW-1:0]           LAST = GW'(GATE_CYCLES - 1);

  logic a_f, b_f;
  logic [1:0] ab_q, ab_d, diff;
  step_t step;

  state_t state_q, state_d;
  logic [GW-1:0] gate_q, gate_d;
  logic signed [CNT_W-1:0] win_q, win_d, win_sum;
  logic signed [CNT_W-1:0] speed_q, speed_d;
  logic signed [31:0] pos_q, pos_d;
  logic valid_q, valid_d;
  logic sat_q, sat_d, quad_q, quad_d;
  logic clamp, sat_set;

  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(ACLK), .rst_n(ARESETN), .din(bus.enc_a), .dout(a_f)
  );
  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(ACLK), .rst_n(ARESETN), .din(bus.enc_b), .dout(b_f)
  );

  assign ab_d = {a_f, b_f};
  assign diff = gray_idx(ab_d) - gray_idx(ab_q);

  // A Gray distance of 2 means both lines moved at once.
  always_comb begin
    step = STEP_NONE;
    unique case (diff)
      2'd0: step = STEP_NONE;
      2'd1: step = STEP_FWD;
      2'd3: step = STEP_REV;
      2'd2: step = STEP_ERR;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    win_d   = win_q;
    speed_d = speed_q;
    valid_d = 1'b0;
    pos_d   = pos_q;
    win_sum = win_q;
    clamp   = 1'b0;
    sat_set = 1'b0;

    if (step == STEP_FWD) begin
      pos_d = pos_q + 32'sd1;
      if (win_q == SMAX) clamp = 1'b1;
      else win_sum = win_q + ONE;
    end else if (step == STEP_REV) begin
      pos_d = pos_q - 32'sd1;
      if (win_q == SMIN) clamp = 1'b1;
      else win_sum = win_q - ONE;
    end

    unique case (state_q)
      IDLE: begin
        gate_d = '0;
        win_d  = '0;
        if (bus.enable) state_d = RUN;
      end
      RUN: begin
        if (!bus.enable) begin
          state_d = IDLE;
          gate_d  = '0;
          win_d   = '0;
        end else begin
          sat_set = clamp;
          if (gate_q == LAST) begin
            speed_d = win_sum;
            valid_d = 1'b1;
            gate_d  = '0;
            win_d   = '0;
          end else begin
            gate_d = gate_q + GW'(1);
            win_d  = win_sum;
          end
        end
      end
    endcase

    // A fresh error outranks a simultaneous clear.
    sat_d  = (sat_q & ~bus.clr_err) | sat_set;
    quad_d = (quad_q & ~bus.clr_err) | (step == STEP_ERR);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ab_q    <= 2'b00;
      state_q <= IDLE;
      gate_q  <= '0;
      win_q   <= '0;
      speed_q <= '0;
      valid_q <= 1'b0;
      pos_q   <= '0;
      sat_q   <= 1'b0;
      quad_q  <= 1'b0;
    end else begin
      ab_q    <= ab_d;
      state_q <= state_d;
      gate_q  <= gate_d;
      win_q   <= win_d;
      speed_q <= speed_d;
      valid_q <= valid_d;
      pos_q   <= pos_d;
      sat_q   <= sat_d;
      quad_q  <= quad_d;
    end
  end

  assign bus.speed       = speed_q;
  assign bus.speed_valid = valid_q;
  assign bus.pos         = pos_q;
  assign bus.sat_err     = sat_q;
  assign bus.quad_err    = quad_q;
endmodule
